// File: rtl/uart_tx_if.sv
// Byte handshake between an upstream producer and the UART transmitter.
// master drives data/valid, slave (uart_tx) returns ready.
interface uart_tx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits, paced by baud_tick.
// Define UART_TX_PARITY_EN to insert a parity bit after the data (odd when PARITY_ODD=1, else even).
module uart_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     baud_tick,
    uart_tx_if.slave host,
    output logic     tx,
    output logic     tx_busy,
    output logic     tx_done
);

    localparam int unsigned BIT_CNT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned STOP_CNT_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

    localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [STOP_CNT_W-1:0] STOP_LAST = STOP_CNT_W'(STOP_BITS - 1);

    // Reject unsupported configurations at elaboration.
    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_tx: parameter out of range");
    end

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_SENSE = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PEND   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PEND   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        STOP   = 3'd5
    } state_t;
`endif

    state_t                 state_q, state_n;
    logic [DATA_BITS-1:0]   shreg_q, shreg_n;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_n;
    logic [STOP_CNT_W-1:0]  stop_cnt_q, stop_cnt_n;
    logic                   tx_n;
    logic                   ready_q, ready_n;
    logic                   busy_n;
    logic                   done_n;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_n;
`endif

    assign host.tx_ready = ready_q;

    // State and registered outputs; reset aborts any frame and parks the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            tx         <= 1'b1;
            ready_q    <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_n;
            shreg_q    <= shreg_n;
            bit_cnt_q  <= bit_cnt_n;
            stop_cnt_q <= stop_cnt_n;
            tx         <= tx_n;
            ready_q    <= ready_n;
            tx_busy    <= busy_n;
            tx_done    <= done_n;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_n;
`endif
        end
    end

    // Next state: handshake only in IDLE, every other move waits for baud_tick.
    always_comb begin
        state_n    = state_q;
        shreg_n    = shreg_q;
        bit_cnt_n  = bit_cnt_q;
        stop_cnt_n = stop_cnt_q;
        tx_n       = tx;
        done_n     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_n   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                tx_n = 1'b1;
                if (host.tx_valid && ready_q) begin
                    shreg_n    = host.tx_data;
                    bit_cnt_n  = '0;
                    stop_cnt_n = '0;
                    state_n    = PEND;
`ifdef UART_TX_PARITY_EN
                    parity_n   = (^host.tx_data) ^ PARITY_SENSE;
`endif
                end
            end

            PEND: begin
                if (baud_tick) begin
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end

            START: begin
                if (baud_tick) begin
                    state_n = DATA;
                    tx_n    = shreg_q[0];
                    shreg_n = shreg_q >> 1;
                end
            end

            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = parity_q;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        tx_n      = shreg_q[0];
                        shreg_n   = shreg_q >> 1;
                        bit_cnt_n = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
`endif

            STOP: begin
                if (baud_tick) begin
                    tx_n = 1'b1;
                    if (stop_cnt_q == STOP_LAST) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        stop_cnt_n = stop_cnt_q + STOP_CNT_W'(1);
                    end
                end
            end

            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        ready_n = (state_n == IDLE);
        busy_n  = (state_n != IDLE);
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: baud_tick every 4 clks, frames checked bit by bit against hand-built patterns.
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       baud_tick;
    logic [7:0] data;
    logic [3:0] valid;
    logic [3:0] tx_v, busy_v, done_v, rdy_v;
    logic [1:0] sel;
    int         phase;
    int         n_cmp;
    int         n_fail;

    logic tx_m, busy_m, done_m, rdy_m;
    assign tx_m   = tx_v[sel];
    assign busy_m = busy_v[sel];
    assign done_m = done_v[sel];
    assign rdy_m  = rdy_v[sel];

    uart_tx_if #(.DATA_BITS(8)) if0 ();
    uart_tx_if #(.DATA_BITS(8)) if1 ();
    assign if0.tx_data  = data;
    assign if0.tx_valid = valid[0];
    assign rdy_v[0]     = if0.tx_ready;
    assign if1.tx_data  = data;
    assign if1.tx_valid = valid[1];
    assign rdy_v[1]     = if1.tx_ready;

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .host(if0),
        .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));

    uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .host(if1),
        .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));

`ifdef UART_TX_PARITY_EN
    uart_tx_if #(.DATA_BITS(8)) if2 ();
    uart_tx_if #(.DATA_BITS(8)) if3 ();
    assign if2.tx_data  = data;
    assign if2.tx_valid = valid[2];
    assign rdy_v[2]     = if2.tx_ready;
    assign if3.tx_data  = data;
    assign if3.tx_valid = valid[3];
    assign rdy_v[3]     = if3.tx_ready;

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .host(if2),
        .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .host(if3),
        .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));
`else
    assign tx_v[3:2]   = 2'b11;
    assign busy_v[3:2] = 2'b00;
    assign done_v[3:2] = 2'b00;
    assign rdy_v[3:2]  = 2'b00;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] b32(input logic v);
        return {31'd0, v};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: present the tick for the coming edge, then sample 1ns after it.
    task automatic clk_cycle();
        baud_tick = (phase == 3);
        @(posedge clk);
        #1;
        phase = (phase + 1) % 4;
    endtask

    // Expected line pattern: start, data LSB first, optional parity, stop bits.
    task automatic build(input logic [7:0] d, input int stop_bits, input logic odd,
                         output logic [15:0] bits, output int n);
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        n = 9;
`ifdef UART_TX_PARITY_EN
        bits[n] = (^d) ^ odd;
        n++;
`else
        if (odd) n = 9;
`endif
        for (int s = 0; s < stop_bits; s++) begin
            bits[n] = 1'b1;
            n++;
        end
    endtask

    task automatic send(input logic [1:0] k, input logic [7:0] d, input bit on_tick, input bit keep);
        int w;
        w      = 0;
        sel    = k;
        data   = d;
        valid[k] = 1'b1;
        while (!(rdy_v[k] === 1'b1 && (!on_tick || phase == 3)) && w < 40) begin
            clk_cycle();
            w++;
        end
        check("hs_ready", b32(rdy_v[k]), 32'd1);
        clk_cycle();
        if (!keep) valid[k] = 1'b0;
        check("hs_busy", b32(busy_v[k]), 32'd1);
        check("hs_not_ready", b32(rdy_v[k]), 32'd0);
    endtask

    task automatic wait_start(output int w);
        w = 0;
        while (tx_m !== 1'b0 && w < 12) begin
            clk_cycle();
            w++;
        end
        check("start_seen", b32(tx_m), 32'd0);
    endtask

    // Every bit must sit on tx for exactly 4 clocks; done fires right after the last stop bit.
    task automatic expect_frame(input string tag, input logic [15:0] bits, input int n, output int w);
        logic ok, busy_ok;
        int   done_seen;
        wait_start(w);
        busy_ok   = 1'b1;
        done_seen = 0;
        for (int i = 0; i < n; i++) begin
            ok = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (tx_m !== bits[i]) ok = 1'b0;
                if (busy_m !== 1'b1) busy_ok = 1'b0;
                if (done_m === 1'b1) done_seen++;
                clk_cycle();
            end
            check($sformatf("%s_bit%0d", tag, i), b32(ok), 32'd1);
        end
        check({tag, "_busy_span"}, b32(busy_ok), 32'd1);
        check({tag, "_no_early_done"}, done_seen, 32'd0);
        check({tag, "_done"}, b32(done_m), 32'd1);
        check({tag, "_idle_tx"}, b32(tx_m), 32'd1);
        check({tag, "_ready"}, b32(rdy_m), 32'd1);
        check({tag, "_not_busy"}, b32(busy_m), 32'd0);
    endtask

    initial begin
        logic [15:0] bits;
        int          n, w;
        logic        clean;

        n_cmp     = 0;
        n_fail    = 0;
        phase     = 0;
        sel       = 2'd0;
        rst_n     = 1'b0;
        baud_tick = 1'b0;
        data      = 8'h00;
        valid     = 4'b0000;

        // Reset values
        for (int i = 0; i < 3; i++) clk_cycle();
        check("rst_tx", b32(tx_m), 32'd1);
        check("rst_ready", b32(rdy_m), 32'd1);
        check("rst_busy", b32(busy_m), 32'd0);
        check("rst_done", b32(done_m), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) clk_cycle();

        // 0x55 single frame, done is a single-cycle pulse
        send(2'd0, 8'h55, 1'b0, 1'b0);
        build(8'h55, 1, 1'b0, bits, n);
        expect_frame("f55", bits, n, w);
        clk_cycle();
        check("f55_done_width", b32(done_m), 32'd0);
        for (int i = 0; i < 5; i++) clk_cycle();

        // Back-to-back with tx_valid held: 0xA3 then 0x0F
        send(2'd0, 8'hA3, 1'b0, 1'b1);
        data = 8'h0F;
        build(8'hA3, 1, 1'b0, bits, n);
        expect_frame("fA3", bits, n, w);
        clk_cycle();
        valid[0] = 1'b0;
        check("b2b_hs_busy", b32(busy_m), 32'd1);
        check("b2b_done_cleared", b32(done_m), 32'd0);
        build(8'h0F, 1, 1'b0, bits, n);
        expect_frame("f0F", bits, n, w);
        check("b2b_pend_clks", w, 32'd3);
        for (int i = 0; i < 5; i++) clk_cycle();

        // Data change after handshake is ignored
        send(2'd0, 8'h00, 1'b0, 1'b0);
        data = 8'hFF;
        build(8'h00, 1, 1'b0, bits, n);
        expect_frame("f00", bits, n, w);
        for (int i = 0; i < 5; i++) clk_cycle();

        // Reset during data bit 3 aborts the frame asynchronously
        send(2'd0, 8'h00, 1'b0, 1'b0);
        wait_start(w);
        for (int i = 0; i < 17; i++) clk_cycle();
        check("abort_mid_bit3", b32(tx_m), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_tx", b32(tx_m), 32'd1);
        check("abort_ready", b32(rdy_m), 32'd1);
        check("abort_busy", b32(busy_m), 32'd0);
        check("abort_done", b32(done_m), 32'd0);
        clk_cycle();
        clk_cycle();
        rst_n = 1'b1;
        clean = 1'b1;
        for (int i = 0; i < 40; i++) begin
            clk_cycle();
            if (tx_m !== 1'b1 || done_m !== 1'b0 || busy_m !== 1'b0) clean = 1'b0;
        end
        check("abort_quiet", b32(clean), 32'd1);

        // Fresh frame after the abort
        send(2'd0, 8'h3C, 1'b0, 1'b0);
        build(8'h3C, 1, 1'b0, bits, n);
        expect_frame("f3C", bits, n, w);
        for (int i = 0; i < 3; i++) clk_cycle();

        // Two stop bits, handshake coinciding with a tick
        send(2'd1, 8'h80, 1'b1, 1'b0);
        build(8'h80, 2, 1'b0, bits, n);
        expect_frame("f80_2stop", bits, n, w);
        check("tick_hs_pend_clks", w, 32'd4);
        for (int i = 0; i < 3; i++) clk_cycle();

`ifdef UART_TX_PARITY_EN
        // 0x07: even parity bit 1, odd parity bit 0
        send(2'd2, 8'h07, 1'b0, 1'b0);
        bits = 16'b1111_1110_0000_1110;
        expect_frame("f07_even", bits, 11, w);
        for (int i = 0; i < 3; i++) clk_cycle();
        send(2'd3, 8'h07, 1'b0, 1'b0);
        bits = 16'b1111_1100_0000_1110;
        expect_frame("f07_odd", bits, 11, w);
        for (int i = 0; i < 3; i++) clk_cycle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
